// File: rtl/fake_tpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fake_tpi_pkg
// Description : Shared types and register-map helpers for fake_tpi_gen.
//               Register offsets depend only on the port count N:
//               PR 0..N-1, DDR N..2N-1, EDGE 2N, MASK 2N+1, AIR 2N+2,
//               HSCR 2N+3, VEC 2N+4.
// Revision    : 1.0 - initial release
// ============================================================================
package fake_tpi_pkg;

    typedef enum logic [1:0] {
        HS_HANDSHAKE = 2'b00,
        HS_PULSE     = 2'b01,
        HS_LOW       = 2'b10,
        HS_HIGH      = 2'b11
    } hs_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        PULSE = 2'b10
    } hs_state_t;

    function automatic int reg_pr(input int k);
        return k;
    endfunction

    function automatic int reg_ddr(input int n, input int k);
        return n + k;
    endfunction

    function automatic int reg_edge(input int n);
        return 2 * n;
    endfunction

    function automatic int reg_mask(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int reg_air(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int reg_hscr(input int n);
        return 2 * n + 3;
    endfunction

    function automatic int reg_vec(input int n);
        return 2 * n + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpi_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tpi_handshake
// Description : One handshake strobe channel.
//               mode 00 handshake: strobe low from a port access until an
//                                  active ack edge.
//               mode 01 pulse    : strobe low for PULSE_LEN clocks after a
//                                  port access; retrigger reloads.
//               mode 10/11       : strobe forced low / high.
// Ports       : clock, _reset (async active-low)
//               mode        - current mode bits
//               mode_wr     - mode register being written this clock
//               mode_new    - mode bits being written
//               port_access - read or write of the associated port
//               ack_edge    - active edge of the associated irq input
//               hs          - registered strobe output
// Revision    : 1.0 - initial release
// ============================================================================
module tpi_handshake
    import fake_tpi_pkg::*;
#(
    parameter int PULSE_LEN = 4
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic [1:0] mode,
    input  logic       mode_wr,
    input  logic [1:0] mode_new,
    input  logic       port_access,
    input  logic       ack_edge,
    output logic       hs
);

    localparam int              CNT_W      = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    // Counter holds the number of low clocks remaining after the current one.
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    hs_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hs;

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hs    <= 1'b1;
        end else if (mode_wr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hs    <= (hs_mode_t'(mode_new) != HS_LOW);
        end else begin
            case (hs_mode_t'(mode))
                HS_HANDSHAKE: begin
                    // A new access wins over a coincident ack edge.
                    if (port_access) begin
                        r_state <= WAIT;
                        r_hs    <= 1'b0;
                    end else if (r_state == WAIT && ack_edge) begin
                        r_state <= IDLE;
                        r_hs    <= 1'b1;
                    end
                end
                HS_PULSE: begin
                    if (port_access) begin
                        r_state <= PULSE;
                        r_cnt   <= C_CNT_LOAD;
                        r_hs    <= 1'b0;
                    end else if (r_state == PULSE) begin
                        if (r_cnt == '0) begin
                            r_state <= IDLE;
                            r_hs    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - C_CNT_ONE;
                        end
                    end
                end
                HS_LOW: begin
                    r_state <= IDLE;
                    r_hs    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_hs    <= 1'b1;
                end
            endcase
        end
    end

    assign hs = r_hs;

endmodule
`default_nettype wire

// File: rtl/fake_tpi_gen.sv
`default_nettype none
// ============================================================================
// Module      : fake_tpi_gen
// Description : Parametrised tri-port-interface successor. NUM_PORTS I/O
//               ports with data direction registers, edge-programmable
//               interrupt latch with mask / priority vector / write-1-clear,
//               and NUM_HS handshake strobe channels.
// Ports       : clock, _reset (async active-low)
//               _cs, _write, addr, wdata   - synchronous host bus
//               rdata, rdata_oe            - registered read data / valid
//               pin_in, pin_out, pin_oe    - port pins, outputs, enables
//               irq_in                     - async interrupt / ack inputs
//               hs_out                     - handshake strobes
//               irq_n                      - registered active-low request
// Options     : FAKE_TPI_AUTOACK_EN - a VEC read with pending set clears the
//               reported latch bit in the same clock.
// Revision    : 1.0 - initial release
// ============================================================================
module fake_tpi_gen
    import fake_tpi_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 8,
    parameter int NUM_IRQ   = 5,
    parameter int NUM_HS    = 2,
    parameter int PULSE_LEN = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                        clock,
    input  logic                        _reset,
    input  logic                        _cs,
    input  logic                        _write,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [PORT_W-1:0]           wdata,
    output logic [PORT_W-1:0]           rdata,
    output logic                        rdata_oe,
    input  logic [NUM_PORTS*PORT_W-1:0] pin_in,
    output logic [NUM_PORTS*PORT_W-1:0] pin_out,
    output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
    input  logic [NUM_IRQ-1:0]          irq_in,
    output logic [NUM_HS-1:0]           hs_out,
    output logic                        irq_n
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [PORT_W-1:0]           r_pr  [NUM_PORTS];
    logic [PORT_W-1:0]           r_ddr [NUM_PORTS];
    logic [NUM_IRQ-1:0]          r_edge, r_mask, r_latch;
    logic [NUM_IRQ-1:0]          r_irq_s1, r_irq_s2, r_irq_s3;
    logic [2*NUM_HS-1:0]         r_hscr;
    logic [NUM_PORTS*PORT_W-1:0] r_pin_s1, r_pin_s2;
    logic [PORT_W-1:0]           r_rdata;
    logic                        r_rdata_oe;
    logic                        r_irq_n;

    int                 w_addr;
    logic               w_acc, w_wr, w_rd;
    logic [NUM_IRQ-1:0] w_act, w_pend_vec, w_clr, w_latch_next, w_mask_next;
    logic               w_pending;
    logic [IDX_W-1:0]   w_index;
    logic [PORT_W-1:0]  w_vec, w_rd_val;

    assign w_addr = int'(addr);
    assign w_acc  = ~_cs;
    assign w_wr   = w_acc & ~_write;
    assign w_rd   = w_acc &  _write;

    // Active edge per input, polarity chosen by EDGE (1 = rising).
    assign w_act = (r_irq_s2 & ~r_irq_s3 & r_edge) | (~r_irq_s2 & r_irq_s3 & ~r_edge);

    // Lowest-index pending masked interrupt.
    always_comb begin
        w_pend_vec = r_latch & r_mask;
        w_pending  = |w_pend_vec;
        w_index    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend_vec[i]) w_index = IDX_W'(i);
        end
        w_vec                 = '0;
        w_vec[IDX_W-1:0]      = w_index;
        w_vec[PORT_W-1]       = w_pending;
    end

    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_addr == reg_pr(k))
                w_rd_val = (r_pr[k] & r_ddr[k]) | (r_pin_s2[k*PORT_W +: PORT_W] & ~r_ddr[k]);
            if (w_addr == reg_ddr(NUM_PORTS, k))
                w_rd_val = r_ddr[k];
        end
        if (w_addr == reg_edge(NUM_PORTS)) w_rd_val = PORT_W'(r_edge);
        if (w_addr == reg_mask(NUM_PORTS)) w_rd_val = PORT_W'(r_mask);
        if (w_addr == reg_air(NUM_PORTS))  w_rd_val = PORT_W'(r_latch);
        if (w_addr == reg_hscr(NUM_PORTS)) w_rd_val = PORT_W'(r_hscr);
        if (w_addr == reg_vec(NUM_PORTS))  w_rd_val = w_vec;
    end

    // Clear terms are applied before set so a coincident edge wins.
    always_comb begin
        w_clr = '0;
        if (w_wr && w_addr == reg_air(NUM_PORTS))
            w_clr = wdata[NUM_IRQ-1:0];
`ifdef FAKE_TPI_AUTOACK_EN
        if (w_rd && w_addr == reg_vec(NUM_PORTS) && w_pending)
            w_clr = w_clr | (NUM_IRQ'(1) << w_index);
`endif
        w_latch_next = (r_latch & ~w_clr) | w_act;
        w_mask_next  = (w_wr && w_addr == reg_mask(NUM_PORTS)) ? wdata[NUM_IRQ-1:0] : r_mask;
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_pr[k]  <= '0;
                r_ddr[k] <= '0;
            end
            r_edge     <= '0;
            r_mask     <= '0;
            r_latch    <= '0;
            r_hscr     <= '0;
            r_irq_s1   <= '0;
            r_irq_s2   <= '0;
            r_irq_s3   <= '0;
            r_pin_s1   <= '0;
            r_pin_s2   <= '0;
            r_rdata    <= '0;
            r_rdata_oe <= 1'b0;
            r_irq_n    <= 1'b1;
        end else begin
            r_pin_s1 <= pin_in;
            r_pin_s2 <= r_pin_s1;
            r_irq_s1 <= irq_in;
            r_irq_s2 <= r_irq_s1;
            r_irq_s3 <= r_irq_s2;
            r_latch  <= w_latch_next;
            r_mask   <= w_mask_next;
            // Computed from next-state values so irq_n tracks the latch.
            r_irq_n  <= ~|(w_latch_next & w_mask_next);
            if (w_wr) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (w_addr == reg_pr(k))             r_pr[k]  <= wdata;
                    if (w_addr == reg_ddr(NUM_PORTS, k)) r_ddr[k] <= wdata;
                end
                if (w_addr == reg_edge(NUM_PORTS)) r_edge <= wdata[NUM_IRQ-1:0];
                if (w_addr == reg_hscr(NUM_PORTS)) r_hscr <= wdata[2*NUM_HS-1:0];
            end
            r_rdata_oe <= w_rd;
            if (w_rd) r_rdata <= w_rd_val;
        end
    end

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
            assign pin_out[k*PORT_W +: PORT_W] = r_pr[k];
            assign pin_oe[k*PORT_W +: PORT_W]  = r_ddr[k];
        end

        for (genvar k = 0; k < NUM_HS; k++) begin : g_hs
            tpi_handshake #(
                .PULSE_LEN (PULSE_LEN)
            ) u_hs (
                .clock       (clock),
                ._reset      (_reset),
                .mode        (r_hscr[2*k +: 2]),
                .mode_wr     (w_wr && (w_addr == reg_hscr(NUM_PORTS))),
                .mode_new    (wdata[2*k +: 2]),
                .port_access (w_acc && (w_addr == reg_pr(k))),
                .ack_edge    (w_act[k]),
                .hs          (hs_out[k])
            );
        end
    endgenerate

    assign rdata    = r_rdata;
    assign rdata_oe = r_rdata_oe;
    assign irq_n    = r_irq_n;

endmodule
`default_nettype wire

// File: doc/fake_tpi_gen.md
Name: fake_tpi_gen

Overview:
Parametrised tri-port-interface successor: NUM_PORTS general I/O ports of PORT_W bits, each with a data direction register.
Adds a synchronous host bus, an edge-programmable interrupt controller with mask, priority vector and write-1-to-clear, and per-channel handshake strobe FSMs.
Sits between the drive-side CPU bus and the parallel/handshake lines, as the generalised replacement for the fixed 3x8 TPI.

Parameters:
NUM_PORTS, 3, number of I/O ports (1..8)
PORT_W, 8, port and data-bus width; also register width
NUM_IRQ, 5, interrupt inputs (<= PORT_W)
NUM_HS, 2, handshake channels; channel k strobes on accesses to port k (<= NUM_PORTS, <= PORT_W/2)
PULSE_LEN, 4, strobe low time in pulse mode, clocks (>= 1)
ADDR_W, 4, register address width (2^ADDR_W >= 2*NUM_PORTS+5)

Ports:
clock  in  1  single clock; every flop is on its rising edge
_reset  in  1  asynchronous active-low reset
_cs  in  1  active-low select; each clock with _cs=0 is one bus access
_write  in  1  active-low write, sampled with _cs
addr  in  ADDR_W  register select
wdata  in  PORT_W  write data
rdata  out  PORT_W  registered read data
rdata_oe  out  1  high the cycle after a read access
pin_in  in  NUM_PORTS*PORT_W  port pin inputs
pin_out  out  NUM_PORTS*PORT_W  port output register values
pin_oe  out  NUM_PORTS*PORT_W  per-bit output enable (= DDR bit)
irq_in  in  NUM_IRQ  asynchronous interrupt/ack inputs
hs_out  out  NUM_HS  handshake strobes (CA, CB, ...)
irq_n  out  1  active-low registered interrupt request

Behaviour:
- Reset (async assert, sync release): all registers 0, pin_out=0, pin_oe=0, rdata=0, rdata_oe=0, hs_out all 1, irq_n=1, irq synchronisers 0.
- Register map, N=NUM_PORTS:
  - 0..N-1 PR.
  - N..2N-1 DDR.
  - 2N EDGE: bit i=1 rising, 0 falling, for irq_in[i].
  - 2N+1 MASK.
  - 2N+2 AIR: read = latch; write-1-clears.
  - 2N+3 HSCR: bits [2k+1:2k] set the mode of channel k.
  - 2N+4 VEC: read-only, {pending, lowest pending masked index}, zero-extended.
- Unmapped addresses read 0; writes to them and to VEC are ignored. Unused AIR, MASK and EDGE bits read 0.
- Write: on the access clock. Effect visible the next cycle.
- Read: rdata and rdata_oe are valid one clock after the access. rdata holds until the next read.
- PR read returns (PR & DDR) | (pin_sync & ~DDR). pin_sync is pin_in through 2 flops.
- irq_in passes through a 2-flop synchroniser, then an edge detector against the previous synchronised value. Input-to-latch latency is 3 clocks.
- Latch: an active edge sets latch[i] regardless of MASK.
  - Set and W1C clear in the same cycle: set wins.
- irq_n = ~|(latch & MASK), registered.
- HS modes:
  - 00 handshake: IDLE(hs=1) -> WAIT(hs=0) on any read or write of port k. WAIT -> IDLE on an active edge of irq_in[k]. A further port access while in WAIT stays in WAIT.
  - 01 pulse: IDLE -> PULSE on a port access. hs=0 for exactly PULSE_LEN clocks, then IDLE. A retrigger during PULSE reloads the counter.
  - 10 force low; 11 force high.
  - A mode write forces the FSM to IDLE, or to the forced level.
- hs_out changes the clock after the triggering access.

Optional Feature:
FAKE_TPI_AUTOACK_EN
- Defined: a read of VEC with pending=1 clears latch[index] in the same cycle. The returned value is the pre-clear vector. A simultaneous set of that same bit wins.
- Undefined: VEC reads have no side effects; latches clear only by AIR write-1.

Decomposition:
- Package fake_tpi_pkg holds:
  - register offset functions of NUM_PORTS (PR, DDR, EDGE, MASK, AIR, HSCR, VEC);
  - HS mode typedef (HS_HANDSHAKE, HS_PULSE, HS_LOW, HS_HIGH);
  - handshake state typedef (IDLE, WAIT, PULSE).
- One sub-module, tpi_handshake: FSM plus PULSE_LEN counter, instantiated NUM_HS times.
- Priority encoder and synchronisers stay inline.

Test Plan:
- Reset with pin_in=all 1 -> read PR0=0x00 (DDR=0 shows pins, but the read at reset gives 0); after 2 clocks, read PR0=0xFF; pin_oe=0; hs_out=2'b11; irq_n=1.
- Write DDR0=0xF0, PR0=0xA5, pin_in[7:0]=0x0C -> pin_out=0xA5, pin_oe=0xF0, PR0 read = 0xAC.
- MASK=0x05, EDGE=0x01; rise irq_in[0], fall irq_in[2] -> irq_n=0 three clocks after the edge; VEC=0x80; write AIR=0x01 -> VEC=0x82; write AIR=0x04 -> irq_n=1.
- HSCR=0b01, PULSE_LEN=4: write PR0 -> hs_out[0] low for exactly 4 clocks. A second write at low-clock 2 -> low 4 clocks from the retrigger.
- HSCR=0b00: read PR0 -> hs_out[0]=0. A second read keeps it 0. Falling edge on irq_in[0] (EDGE bit 0) -> hs_out[0]=1.
- FAKE_TPI_AUTOACK_EN defined: latch=0x06, MASK=0x06 -> read VEC=0x81 then 0x82 then 0x00; irq_n returns to 1. Without the macro -> VEC=0x81 repeatedly.
